// File: rtl/hsv_pkg.sv
// hsv_pkg
// Shared definitions for the HSV mixer fade scheduler.
//   NUM_CHAN        number of PWM channels driven by the scheduler (R, G, B)
//   CHAN_W          width of the command channel index
//   DEF_WIDTH       default PWM level width, matches the hsv_pwm instances
//   DEF_DIV_W       default width of the per-channel period divider
//   chan_e          channel index encoding, CH_INVALID marks a discarded command
package hsv_pkg;

   localparam int NUM_CHAN  = 3;
   localparam int CHAN_W    = 2;
   localparam int DEF_WIDTH = 8;
   localparam int DEF_DIV_W = 8;

   typedef enum logic [CHAN_W-1:0] {
      CH_R       = 2'd0,
      CH_G       = 2'd1,
      CH_B       = 2'd2,
      CH_INVALID = 2'd3
   } chan_e;

endpackage

// File: rtl/hsv_fade_chan.sv
// hsv_fade_chan
// One channel of the fade scheduler. Holds the current level, the fade target,
// the step size and the period divider, and moves the level toward the target
// only on PWM period boundaries.
//   clk, reset    clock and synchronous active-high reset
//   boundary      high on the last cycle of a PWM period
//   load          apply a new command to this channel at this boundary
//   load_target   commanded final level
//   load_step     commanded increment per step, 0 jumps straight to the target
//   load_div      commanded number of extra periods between steps
//   level         current PWM level
//   busy          high while level differs from target
module hsv_fade_chan
   import hsv_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DIV_W = DEF_DIV_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             boundary,
   input  logic             load,
   input  logic [WIDTH-1:0] load_target,
   input  logic [WIDTH-1:0] load_step,
   input  logic [DIV_W-1:0] load_div,
   output logic [WIDTH-1:0] level,
   output logic             busy
);

   logic [WIDTH-1:0] target;
   logic [WIDTH-1:0] step;
   logic [DIV_W-1:0] div;
   logic [DIV_W-1:0] dcnt;

   logic [WIDTH-1:0] next_level;
   logic [WIDTH-1:0] next_target;
   logic [WIDTH-1:0] next_step;
   logic [DIV_W-1:0] next_div;
   logic [DIV_W-1:0] next_dcnt;

   logic [WIDTH:0]   diff_up;
   logic [WIDTH:0]   diff_dn;
   logic [WIDTH:0]   step_ext;

   // Next-state logic for the channel. Nothing moves outside a boundary.
   // A load replaces the fade parameters and restarts the divider; the level
   // only moves on a load when the step is zero (a direct jump). Otherwise the
   // divider counts down, and once it is exhausted the level takes one step
   // toward the target. The remaining distance is compared against the step in
   // WIDTH+1 bits so the last step lands exactly on the target instead of
   // overshooting or wrapping.
   always_comb begin
      next_level  = level;
      next_target = target;
      next_step   = step;
      next_div    = div;
      next_dcnt   = dcnt;
      diff_up     = {1'b0, target} - {1'b0, level};
      diff_dn     = {1'b0, level} - {1'b0, target};
      step_ext    = {1'b0, step};
      if (boundary) begin
         if (load) begin
            next_target = load_target;
            next_step   = load_step;
            next_div    = load_div;
            next_dcnt   = load_div;
            if (load_step == '0) begin
               next_level = load_target;
            end
         end else if (dcnt != '0) begin
            next_dcnt = dcnt - DIV_W'(1);
         end else if (level != target) begin
            if (target > level) begin
               next_level = (diff_up <= step_ext) ? target : level + step;
            end else begin
               next_level = (diff_dn <= step_ext) ? target : level - step;
            end
            next_dcnt = div;
         end
      end
   end

   // Channel state register. Busy is registered from the next-state values so
   // it changes on the same edge as the level it describes.
   always_ff @(posedge clk) begin
      if (reset) begin
         level  <= '0;
         target <= '0;
         step   <= '0;
         div    <= '0;
         dcnt   <= '0;
         busy   <= 1'b0;
      end else begin
         level  <= next_level;
         target <= next_target;
         step   <= next_step;
         div    <= next_div;
         dcnt   <= next_dcnt;
         busy   <= (next_level != next_target);
      end
   end

endmodule

// File: rtl/hsv_fade_ctrl.sv
// hsv_fade_ctrl
// Level scheduler for the R, G and B hsv_pwm channels. Accepts fade commands
// over a valid/ready interface into a single pending slot, and hands them to
// the addressed channel at the next PWM period boundary so that level changes
// never land mid-period.
//   clk, reset      clock and synchronous active-high reset, shared with hsv_pwm
//   cmd_valid       command offered
//   cmd_ready       pending slot free (low during reset)
//   cmd_chan        target channel, 0=R 1=G 2=B 3=invalid (discarded)
//   cmd_target      final level
//   cmd_step        level increment per step, 0 jumps directly
//   cmd_div         extra PWM periods between steps
//   level           {B,G,R} levels for the hsv_pwm instances
//   busy            per channel, high while level != target
//   period_start    one-cycle pulse on the first cycle of each PWM period
module hsv_fade_ctrl
   import hsv_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DIV_W = DEF_DIV_W
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic [CHAN_W-1:0]         cmd_chan,
   input  logic [WIDTH-1:0]          cmd_target,
   input  logic [WIDTH-1:0]          cmd_step,
   input  logic [DIV_W-1:0]          cmd_div,
   output logic [NUM_CHAN*WIDTH-1:0] level,
   output logic [NUM_CHAN-1:0]       busy,
   output logic                      period_start
);

   logic [WIDTH-1:0] cnt;
   logic             boundary;
   logic             accept;

   logic             pending;
   chan_e            pend_chan;
   logic [WIDTH-1:0] pend_target;
   logic [WIDTH-1:0] pend_step;
   logic [DIV_W-1:0] pend_div;

   // The boundary is the last cycle of a period; channel updates registered on
   // its edge become visible when the counter wraps to zero, matching the
   // hsv_pwm counters that run in lockstep with this one.
   assign boundary  = (cnt == '1);
   assign cmd_ready = !pending && !reset;
   assign accept    = cmd_valid && cmd_ready;

   // Period counter, period_start pulse and the pending command slot. A
   // command is only ever stored on the edge it is accepted; the slot is only
   // drained at a boundary. Because acceptance requires an empty slot, the two
   // never happen on the same edge, which is what pushes a command accepted on
   // a boundary cycle out by one full period.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt          <= '0;
         period_start <= 1'b0;
         pending      <= 1'b0;
         pend_chan    <= CH_R;
         pend_target  <= '0;
         pend_step    <= '0;
         pend_div     <= '0;
      end else begin
         cnt          <= cnt + WIDTH'(1);
         period_start <= boundary;
         if (boundary && pending) begin
            pending <= 1'b0;
         end
         if (accept) begin
            pending     <= 1'b1;
            pend_chan   <= chan_e'(cmd_chan);
            pend_target <= cmd_target;
            pend_step   <= cmd_step;
            pend_div    <= cmd_div;
         end
      end
   end

   // One fade channel per PWM output. A channel is loaded only when the slot
   // holds a command addressed to it; CH_INVALID matches no channel, so such a
   // command simply drains from the slot.
   for (genvar i = 0; i < NUM_CHAN; i++) begin : g_chan
      logic load;

      assign load = boundary && pending && (pend_chan != CH_INVALID) &&
                    (pend_chan == chan_e'(i));

      hsv_fade_chan #(
         .WIDTH (WIDTH),
         .DIV_W (DIV_W)
      ) u_chan (
         .clk         (clk),
         .reset       (reset),
         .boundary    (boundary),
         .load        (load),
         .load_target (pend_target),
         .load_step   (pend_step),
         .load_div    (pend_div),
         .level       (level[i*WIDTH +: WIDTH]),
         .busy        (busy[i])
      );
   end

endmodule

// File: tb/tb_hsv_fade_ctrl.sv
// tb_hsv_fade_ctrl
// Self-checking bench for hsv_fade_ctrl (WIDTH=8, DIV_W=8). A behavioural
// model tracks the period position, the pending command and each channel's
// fade as plain integers, and every cycle the DUT outputs are compared with it.
// Directed scenarios cover jump, fade up/down, back-pressure, invalid channel
// and reset mid-fade, followed by randomized command traffic.
module tb_hsv_fade_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_chan;
   logic [7:0]  cmd_target;
   logic [7:0]  cmd_step;
   logic [7:0]  cmd_div;
   logic [23:0] level;
   logic [2:0]  busy;
   logic        period_start;

   int checks_total  = 0;
   int checks_passed = 0;

   int m_cnt;
   bit m_pending;
   int p_chan, p_target, p_step, p_div;
   int lv[3], tg[3], st[3], dv[3], dc[3];
   bit m_ps;
   bit m_accepted;
   string phase;

   hsv_fade_ctrl #(.WIDTH(8), .DIV_W(8)) dut (
      .clk          (clk),
      .reset        (reset),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_chan     (cmd_chan),
      .cmd_target   (cmd_target),
      .cmd_step     (cmd_step),
      .cmd_div      (cmd_div),
      .level        (level),
      .busy         (busy),
      .period_start (period_start)
   );

   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks_total++;
      if (actual === expected) begin
         checks_passed++;
      end else begin
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
      end
   endtask

   // Behavioural model of one clock edge, given the inputs offered this cycle.
   task automatic modelEdge(input bit rst, input bit v, input int ch,
                            input int tgt, input int stp, input int dvv);
      bit bnd;
      bit acc;
      m_accepted = 1'b0;
      if (rst) begin
         m_cnt = 0;
         m_pending = 1'b0;
         m_ps = 1'b0;
         for (int c = 0; c < 3; c++) begin
            lv[c] = 0; tg[c] = 0; st[c] = 0; dv[c] = 0; dc[c] = 0;
         end
         return;
      end
      bnd = (m_cnt == 255);
      acc = v && !m_pending;
      if (bnd) begin
         for (int c = 0; c < 3; c++) begin
            if (m_pending && p_chan == c) begin
               tg[c] = p_target; st[c] = p_step; dv[c] = p_div; dc[c] = p_div;
               if (p_step == 0) lv[c] = p_target;
            end else if (dc[c] > 0) begin
               dc[c]--;
            end else if (lv[c] != tg[c]) begin
               if (tg[c] > lv[c]) lv[c] = (lv[c] + st[c] > tg[c]) ? tg[c] : lv[c] + st[c];
               else               lv[c] = (lv[c] - st[c] < tg[c]) ? tg[c] : lv[c] - st[c];
               dc[c] = dv[c];
            end
         end
         m_pending = 1'b0;
      end
      if (acc) begin
         m_pending = 1'b1;
         m_accepted = 1'b1;
         p_chan = ch; p_target = tgt; p_step = stp; p_div = dvv;
      end
      m_ps = bnd;
      m_cnt = (m_cnt + 1) % 256;
   endtask

   // Drives one cycle of inputs at the falling edge, checks cmd_ready before
   // the rising edge, then checks the registered outputs at the next falling edge.
   task automatic applyStimulus(input bit rst, input bit v, input int ch,
                                input int tgt, input int stp, input int dvv);
      logic [23:0] exp_level;
      logic [2:0]  exp_busy;
      reset      = rst;
      cmd_valid  = v;
      cmd_chan   = 2'(ch);
      cmd_target = 8'(tgt);
      cmd_step   = 8'(stp);
      cmd_div    = 8'(dvv);
      #1;
      checkOutput({phase, ":ready"}, 32'(cmd_ready), 32'(!m_pending && !rst));
      modelEdge(rst, v, ch, tgt, stp, dvv);
      @(posedge clk);
      @(negedge clk);
      exp_level = {8'(lv[2]), 8'(lv[1]), 8'(lv[0])};
      exp_busy  = {lv[2] != tg[2], lv[1] != tg[1], lv[0] != tg[0]};
      checkOutput({phase, ":level"}, 32'(level), 32'(exp_level));
      checkOutput({phase, ":busy"}, 32'(busy), 32'(exp_busy));
      checkOutput({phase, ":pstart"}, 32'(period_start), 32'(m_ps));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 0, 0, 0, 0);
   endtask

   task automatic waitCnt(input int k);
      while (m_cnt != k) applyStimulus(1'b0, 1'b0, 0, 0, 0, 0);
   endtask

   task automatic sendAt(input int k, input int ch, input int tgt,
                         input int stp, input int dvv);
      waitCnt(k);
      applyStimulus(1'b0, 1'b1, ch, tgt, stp, dvv);
   endtask

   // Main sequence: directed scenarios from reset through reset mid-fade,
   // then random command traffic.
   initial begin
      int guard;
      phase = "reset";
      m_cnt = 0;
      m_pending = 1'b0;
      m_ps = 1'b0;
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 0, 0, 0, 0);
      checkOutput("reset_level", 32'(level), 32'd0);
      checkOutput("reset_busy", 32'(busy), 32'd0);

      phase = "release";
      idle(257);

      phase = "jump";
      sendAt(10, 0, 200, 0, 0);
      waitCnt(255);
      checkOutput("jump_before", 32'(level[7:0]), 32'd0);
      idle(2);
      checkOutput("jump_after", 32'(level[7:0]), 32'd200);
      checkOutput("jump_gb", 32'(level[23:8]), 32'd0);

      phase = "fade_up";
      sendAt(20, 1, 10, 4, 0);
      for (int i = 0; i < 4; i++) begin
         waitCnt(255);
         idle(1);
      end
      checkOutput("fade_up_final", 32'(level[15:8]), 32'd10);
      checkOutput("fade_up_busy", 32'(busy[1]), 32'd0);

      phase = "fade_down";
      sendAt(30, 2, 100, 0, 0);
      waitCnt(255);
      idle(1);
      sendAt(30, 2, 90, 5, 1);
      for (int i = 0; i < 5; i++) begin
         waitCnt(255);
         idle(1);
      end
      checkOutput("fade_down_final", 32'(level[23:16]), 32'd90);

      phase = "backpressure";
      sendAt(255, 0, 50, 0, 0);
      guard = 0;
      m_accepted = 1'b0;
      while (!m_accepted && guard < 600) begin
         applyStimulus(1'b0, 1'b1, 2, 30, 0, 0);
         guard++;
      end
      checkOutput("bp_second_accepted", 32'(m_accepted), 32'd1);
      waitCnt(255);
      idle(1);
      checkOutput("bp_r_applied", 32'(level[7:0]), 32'd50);
      checkOutput("bp_b_applied", 32'(level[23:16]), 32'd30);

      phase = "invalid";
      sendAt(40, 3, 77, 0, 0);
      waitCnt(255);
      idle(2);
      checkOutput("invalid_levels", 32'(level), {8'd0, 8'd30, 8'd10, 8'd50});

      phase = "reset_mid";
      sendAt(50, 1, 0, 0, 0);
      waitCnt(255);
      idle(1);
      sendAt(50, 1, 40, 4, 0);
      guard = 0;
      while (lv[1] != 8 && guard < 2000) begin
         idle(1);
         guard++;
      end
      checkOutput("reset_mid_reached8", 32'(level[15:8]), 32'd8);
      idle(37);
      applyStimulus(1'b1, 1'b0, 0, 0, 0, 0);
      checkOutput("reset_mid_level", 32'(level), 32'd0);
      checkOutput("reset_mid_busy", 32'(busy), 32'd0);
      idle(300);

      phase = "random";
      for (int i = 0; i < 40 * 256; i++) begin
         if ($urandom_range(0, 47) == 0) begin
            applyStimulus(1'b0, 1'b1, int'($urandom_range(0, 3)),
                          int'($urandom_range(0, 255)), int'($urandom_range(0, 40)),
                          int'($urandom_range(0, 2)));
         end else begin
            applyStimulus(1'b0, 1'b0, 0, 0, 0, 0);
         end
      end

      $display("[TB] %0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule

// File: doc/hsv_fade_ctrl.md
# hsv_fade_ctrl

Level scheduler for the three `hsv_pwm` channels (R, G, B) of the HSV mixer. It accepts per-channel fade commands over a valid/ready interface. It ramps each channel's PWM `level` toward a target in programmable steps and commits every level change only at a PWM period boundary, so no channel ever sees a mid-period glitch. It sits between the command/config logic and three `hsv_pwm` instances that share its `clk`/`reset`.

## Interface
- `WIDTH`, 8: PWM level width; must equal the `hsv_pwm` `WIDTH`.
- `DIV_W`, 8: width of the per-channel period divider.
- `clk` in 1: single clock, shared with all `hsv_pwm` instances.
- `reset` in 1: synchronous, active-high; the same signal drives the `hsv_pwm` resets.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: command slot free.
- `cmd_chan` in 2: channel index, 0=R, 1=G, 2=B, 3=invalid.
- `cmd_target` in WIDTH: final level.
- `cmd_step` in WIDTH: level increment per step; 0 means jump directly to the target.
- `cmd_div` in DIV_W: extra PWM periods between steps.
- `level` out 3*WIDTH: `{B,G,R}` levels, wired to the `hsv_pwm` `level` inputs.
- `busy` out 3: per channel, high while `level != target`.
- `period_start` out 1: one-cycle pulse on the first cycle of each PWM period (count == 0).

## Operation
- **Period counter.** Internal WIDTH-bit counter `cnt`, reset to 0, increments every cycle and wraps. It is cycle-identical to each `hsv_pwm` internal counter.
- **Boundary.** A boundary is the cycle with `cnt == 2^WIDTH-1`. All channel-state updates are registered on the edge of that cycle, so new levels are first visible at `cnt == 0`.
- **Command slot.** A single pending buffer holds one command. `cmd_ready = !pending && !reset`. A transfer happens when `cmd_valid && cmd_ready`. The command is stored in the buffer; it is never applied on the edge where it is accepted, even if that edge is a boundary.
- **Applying a pending command at a boundary.**
  - If `chan` is 0..2: load that channel's `target`, `step`, `div`; set its divider counter `dcnt = div`. Its `level` does not move at this boundary. If `step == 0`, `level` is set to `target` at this boundary.
  - Chan 3: the command is discarded.
  - The pending slot is cleared in either case, so `cmd_ready` is high from the next cycle.
- **Stepping, at each boundary, for every channel not loaded by a command this boundary.**
  - If `dcnt != 0`: decrement `dcnt`.
  - Otherwise, if `level != target`: move `level` toward `target` by `step`, saturating exactly at `target` (never overshooting), then reload `dcnt = div`.
  - If `level == target`: no change.
- **Arithmetic.** Differences are computed in WIDTH+1 bits.
  - Upward: if `target - level <= step`, then `level = target`; else `level + step`.
  - Downward: mirror image.
  - No wrap-around is possible.
- **Reset.** `reset` clears `cnt`, all `level`, `target`, `step`, `div`, `dcnt`, and the pending slot. Reset values: `level` = 0, `busy` = 0, `period_start` = 0, `cmd_ready` = 0 while reset is high. A fade in progress is aborted.

## Timing
- **Command latency.** A command accepted at `cnt = k` takes effect at the next boundary, with the new level visible at `cnt = 0`. The exception is a command accepted exactly at `cnt = 2^WIDTH-1`, which takes effect one full period later.
- **Step cadence.** With `div = d`, steps occur every d+1 periods. The first step comes d+1 boundaries after the command is applied.
- **Back-to-back commands.** A second command is stalled (`cmd_ready` = 0) until the cycle after the next boundary.
- **`busy`.** Registered; updates on the same edge as `level`.
- **`period_start`.** Registered; high exactly when `cnt == 0`, except during the first cycle after reset.

## Structure
- Package `hsv_pkg`:
  - `NUM_CHAN = 3`
  - channel index constants `CH_R`, `CH_G`, `CH_B`, `CH_INVALID`
  - the command field widths
- Sub-module `hsv_fade_chan`, instantiated 3 times. It holds `level`, `target`, `step`, `div`, `dcnt`, plus the saturating step logic. Its inputs are `boundary`, `load`, and the command fields.
- The top level holds `cnt`, the pending slot, and the channel decode.

## Test plan
(WIDTH=8, DIV_W=8)
- **Reset release.** Expect all levels 0 and `busy` = 0. `cmd_ready` is 0 during reset and 1 on the first cycle after. `period_start` first pulses at cycle 256 after reset release.
- **Jump.** `cmd_chan` 0, target 200, step 0, accepted at `cnt` = 10 → R level = 200 from `cnt` = 0 of the next period and not before; G and B stay 0.
- **Fade up with saturation.** `cmd_chan` 1, target 10, step 4, div 0 → G level = 0, 4, 8, 10 at successive boundaries, then holds. `busy[1]` falls together with the 10.
- **Fade down with divider.** B starts at 100; command target 90, step 5, div 1 → B level = 95 two boundaries after the load, 90 two boundaries later.
- **Back-pressure and boundary acceptance.** A command accepted at `cnt` = 255 → `cmd_ready` = 0, the command is applied one period later. A second `cmd_valid` held meanwhile is accepted on the cycle after that boundary. A `chan` = 3 command → no level changes, and the slot frees.
- **Reset mid-fade.** Assert reset during the G ramp (level 8) → the next cycle shows level 0, `busy` 0, `cnt` 0, pending cleared.
